// File: rtl/des_ctrl_pkg.sv
// Shared types and constants for the DES sequencing controller.
package des_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        DONE
    } state_t;

    localparam int DEF_PIPE_LAT  = 17;
    localparam int DEF_DB_CYCLES = 250000;
    localparam int DEF_DB_W      = 18;

    // Active-low decimal points, indexed by word_sel (entry 0 is the rightmost).
    localparam logic [3:0][3:0] DP_TABLE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

endpackage

// File: rtl/pb_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each rising edge of the debounced level.
module pb_debounce
    import des_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int DB_W      = DEF_DB_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic            db_prev_q;
    logic            pulse_q, pulse_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DB_W'(1);
        end
        pulse_d = db_q & ~db_prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/des_ctrl.sv
// DES sequencing controller: launches one encryption per start press, holds
// the plaintext for the core latency, captures ciphertext and feeds the display.
module des_ctrl
    import des_ctrl_pkg::*;
#(
    parameter int PIPE_LAT  = DEF_PIPE_LAT,
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int DB_W      = DEF_DB_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sw,
    input  logic        start_pb,
    input  logic        sel_pb,
    output logic [7:0]  mess_idx,
    input  logic [63:0] mess_in,
    output logic [63:0] des_in,
    input  logic [63:0] des_out,
    output logic [63:0] ct,
    output logic        busy,
    output logic        done,
    output logic [1:0]  word_sel,
    output logic [15:0] disp_data,
    output logic [3:0]  disp_dp,
    output logic [7:0]  led
);

    logic start_p, sel_p;

    pb_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_start_db (
        .clk(clk), .rst(rst), .btn(start_pb), .pulse(start_p)
    );

    pb_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_sel_db (
        .clk(clk), .rst(rst), .btn(sel_pb), .pulse(sel_p)
    );

    state_t      state_q, state_d;
    logic [7:0]  mess_idx_q, mess_idx_d;
    logic [63:0] des_in_q, des_in_d;
    logic [63:0] ct_q, ct_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  word_sel_q, word_sel_d;
    logic [15:0] disp_data_q, disp_data_d;
    logic [3:0]  disp_dp_q, disp_dp_d;

    always_comb begin
        state_d    = state_q;
        mess_idx_d = mess_idx_q;
        des_in_d   = des_in_q;
        ct_d       = ct_q;
        wcnt_d     = wcnt_q;
        word_sel_d = word_sel_q;
        if (sel_p) begin
            word_sel_d = word_sel_q + 2'd1;
        end
        case (state_q)
            IDLE, DONE: begin
                if (start_p) begin
                    mess_idx_d = sw;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                des_in_d = mess_in;
                wcnt_d   = 8'd0;
                state_d  = WAIT;
            end
            WAIT: begin
                wcnt_d = wcnt_q + 8'd1;
                // Capture overrides a coincident select press.
                if (wcnt_q == 8'(PIPE_LAT - 1)) begin
                    ct_d       = des_out;
                    word_sel_d = 2'd0;
                    state_d    = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d == LOAD) || (state_d == WAIT);
        done_d      = (state_d == DONE);
        disp_data_d = ct_q[{word_sel_q, 4'b0000} +: 16];
        disp_dp_d   = DP_TABLE[word_sel_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mess_idx_q  <= '0;
            des_in_q    <= '0;
            ct_q        <= '0;
            wcnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            word_sel_q  <= '0;
            disp_data_q <= '0;
            disp_dp_q   <= 4'b1110;
        end else begin
            state_q     <= state_d;
            mess_idx_q  <= mess_idx_d;
            des_in_q    <= des_in_d;
            ct_q        <= ct_d;
            wcnt_q      <= wcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            word_sel_q  <= word_sel_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
        end
    end

    assign mess_idx  = mess_idx_q;
    assign des_in    = des_in_q;
    assign ct        = ct_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign word_sel  = word_sel_q;
    assign disp_data = disp_data_q;
    assign disp_dp   = disp_dp_q;
    assign led       = sw;

endmodule

// File: tb/tb_des_ctrl.sv
// Self-checking bench for des_ctrl with a ROM stub and a delayed-XOR core stub.
module tb_des_ctrl;

    localparam int PIPE_LAT  = 17;
    localparam int DB_CYCLES = 4;
    localparam int DB_W      = 3;
    localparam logic [63:0] MASK = 64'hFFFF_0000_FFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw;
    logic        start_pb, sel_pb;
    logic [7:0]  mess_idx;
    logic [63:0] mess_in, des_in, des_out, ct;
    logic        busy, done;
    logic [1:0]  word_sel;
    logic [15:0] disp_data;
    logic [3:0]  disp_dp;
    logic [7:0]  led;

    des_ctrl #(.PIPE_LAT(PIPE_LAT), .DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) dut (
        .clk(clk), .rst(rst), .sw(sw), .start_pb(start_pb), .sel_pb(sel_pb),
        .mess_idx(mess_idx), .mess_in(mess_in), .des_in(des_in), .des_out(des_out),
        .ct(ct), .busy(busy), .done(done), .word_sel(word_sel),
        .disp_data(disp_data), .disp_dp(disp_dp), .led(led)
    );

    always #5 clk = ~clk;

    // ROM stub and core stub: output valid PIPE_LAT cycles counting the first cycle des_in is presented.
    assign mess_in = {8{mess_idx}};
    logic [63:0] dly [PIPE_LAT-1];
    always @(posedge clk) begin
        dly[0] <= des_in ^ MASK;
        for (int k = 1; k < PIPE_LAT - 1; k++) dly[k] <= dly[k-1];
    end
    assign des_out = dly[PIPE_LAT-2];

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_ct;
    logic [1:0]  exp_ws;
    logic [7:0]  exp_idx;

    function automatic logic [15:0] disp_of(input logic [63:0] c, input logic [1:0] ws);
        return 16'(c >> (16 * int'(ws)));
    endfunction

    function automatic logic [3:0] dp_of(input logic [1:0] ws);
        return 4'(4'hF ^ (4'd1 << ws));
    endfunction

    task automatic test_reset();
        rst = 1'b1; sw = 8'($urandom); start_pb = 1'b0; sel_pb = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if ({mess_idx, des_in, ct} !== {8'h00, 64'h0, 64'h0}) begin
            errors++; $display("FAIL reset_regs got idx=%h des_in=%h ct=%h want zeros", mess_idx, des_in, ct);
        end
        checks++; if ({busy, done, word_sel} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got busy=%b done=%b ws=%0d want 0", busy, done, word_sel);
        end
        checks++; if ({disp_data, disp_dp} !== {16'h0000, 4'b1110}) begin
            errors++; $display("FAIL reset_disp got %h/%b want 0000/1110", disp_data, disp_dp);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({busy, done, disp_data, ct} !== {2'b00, 16'h0, 64'h0}) begin
            errors++; $display("FAIL post_reset_idle got busy=%b done=%b disp=%h", busy, done, disp_data);
        end
        checks++; if (led !== sw) begin
            errors++; $display("FAIL led got %h want %h", led, sw);
        end
        exp_ct = '0; exp_ws = 2'd0; exp_idx = 8'h00;
    endtask

    // One start press (optional second press), sw scrambled after launch.
    task automatic run_encrypt(input string name, input logic [7:0] idx, input int len,
                               input int second_at, input int second_len);
        int first_busy = -1;
        int busy_cycles = 0;
        int rises = 0;
        logic prev = 1'b0;
        sw = idx;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            start_pb = (i < len) || (i >= second_at && i < second_at + second_len);
            if (i == len + 2) sw = 8'($urandom);
            @(negedge clk);
            if (busy && !prev) begin
                rises++;
                if (first_busy < 0) first_busy = i;
            end
            if (busy) busy_cycles++;
            prev = busy;
        end
        start_pb = 1'b0;
        exp_idx = idx;
        exp_ct  = {8{idx}} ^ MASK;
        exp_ws  = 2'd0;
        checks++; if (first_busy !== DB_CYCLES + 4) begin
            errors++; $display("FAIL %s latency got %0d want %0d", name, first_busy, DB_CYCLES + 4);
        end
        checks++; if (busy_cycles !== PIPE_LAT + 1 || rises !== 1) begin
            errors++; $display("FAIL %s busy got %0d cycles %0d runs want %0d cycles 1 run",
                               name, busy_cycles, rises, PIPE_LAT + 1);
        end
        checks++; if (ct !== exp_ct) begin
            errors++; $display("FAIL %s ct got %h want %h", name, ct, exp_ct);
        end
        checks++; if ({mess_idx, des_in} !== {exp_idx, {8{exp_idx}}}) begin
            errors++; $display("FAIL %s idx got %h des_in=%h want %h", name, mess_idx, des_in, exp_idx);
        end
        checks++; if ({done, busy, word_sel} !== {1'b1, 1'b0, exp_ws}) begin
            errors++; $display("FAIL %s status got done=%b busy=%b ws=%0d want 1/0/0", name, done, busy, word_sel);
        end
        checks++; if ({disp_data, disp_dp} !== {disp_of(exp_ct, exp_ws), dp_of(exp_ws)}) begin
            errors++; $display("FAIL %s disp got %h/%b want %h/%b", name, disp_data, disp_dp,
                               disp_of(exp_ct, exp_ws), dp_of(exp_ws));
        end
    endtask

    task automatic test_word_select();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 16; i++) begin
                @(posedge clk); #1 sel_pb = (i < 6);
            end
            @(negedge clk);
            exp_ws = exp_ws + 2'd1;
            checks++; if ({word_sel, disp_data, disp_dp} !== {exp_ws, disp_of(exp_ct, exp_ws), dp_of(exp_ws)}) begin
                errors++; $display("FAIL word_sel_%0d got ws=%0d %h/%b want ws=%0d %h/%b", p, word_sel,
                                   disp_data, disp_dp, exp_ws, disp_of(exp_ct, exp_ws), dp_of(exp_ws));
            end
        end
    endtask

    task automatic test_bounce();
        int busy_seen = 0;
        for (int r = 0; r < 5; r++) begin
            int hi = int'($urandom_range(1, 2));
            for (int i = 0; i < hi + 3; i++) begin
                @(posedge clk); #1 start_pb = (i < hi);
                @(negedge clk); if (busy) busy_seen++;
            end
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); if (busy) busy_seen++;
        end
        checks++; if (busy_seen !== 0) begin
            errors++; $display("FAIL bounce_busy got %0d busy cycles want 0", busy_seen);
        end
        checks++; if ({done, ct, mess_idx} !== {1'b1, exp_ct, exp_idx}) begin
            errors++; $display("FAIL bounce_state got done=%b ct=%h idx=%h", done, ct, mess_idx);
        end
    endtask

    task automatic test_reset_mid_wait();
        int first_busy = -1;
        int late = 0;
        sw = 8'($urandom);
        for (int i = 0; i < 40 && first_busy < 0; i++) begin
            @(posedge clk); #1 start_pb = (i < 8);
            @(negedge clk); if (busy) first_busy = i;
        end
        checks++; if (first_busy < 0) begin
            errors++; $display("FAIL rst_wait_start got no busy want busy");
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 start_pb = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({mess_idx, des_in, ct, busy, done, word_sel} !== {8'h0, 64'h0, 64'h0, 4'b0000}) begin
            errors++; $display("FAIL rst_wait_async got idx=%h des_in=%h ct=%h busy=%b done=%b",
                               mess_idx, des_in, ct, busy, done);
        end
        checks++; if ({disp_data, disp_dp} !== {16'h0000, 4'b1110}) begin
            errors++; $display("FAIL rst_wait_disp got %h/%b want 0000/1110", disp_data, disp_dp);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); if (busy || done || ct !== 64'h0) late++;
        end
        checks++; if (late !== 0) begin
            errors++; $display("FAIL rst_wait_after got %0d active cycles want 0", late);
        end
    endtask

    initial begin
        test_reset();
        run_encrypt("basic", 8'h05, 10, 1000, 0);
        test_word_select();
        test_bounce();
        run_encrypt("restart", 8'hA0, 10, 12, 10);
        for (int n = 0; n < 3; n++) begin
            run_encrypt("random", 8'($urandom), int'($urandom_range(6, 12)), 1000, 0);
        end
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
